// File: rtl/hazard_ctrl_unit.sv
// Hazard detection and pipeline control beside the ID stage: load-use and HI/LO
// interlocks, branch/jump redirect, stall performance counter and stall watchdog.
module hazard_ctrl_unit #(
  parameter int unsigned AW       = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned MDU_LAT  = 4,
  parameter int unsigned MW       = 3,
  parameter int unsigned CW       = 16,
  parameter int unsigned MAX_HOLD = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] src1_ID,
  input  logic [AW-1:0] src2_ID,
  input  logic          src1_used_ID,
  input  logic          src2_used_ID,
  input  logic          hilo_use_ID,
  input  logic [AW-1:0] dest_EXE,
  input  logic          mem_read_IDEX,
  input  logic [AW-1:0] dest_MEM,
  input  logic          mem_read_EXMEM,
  input  logic          mdu_start_IDEX,
  input  logic          branch,
  input  logic          branchYes,
  input  logic [1:0]    jump,
  output logic          ld_has_hazard,
  output logic          mdu_hazard,
  output logic          branch_has_hazard,
  output logic          hazard,
  output logic          hold,
  output logic          bubble_IDEX,
  output logic          flush_IFID,
  output logic          mdu_busy,
  output logic [CW-1:0] stall_count,
  output logic          hold_timeout
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);

  logic [MW-1:0] mdu_cnt_q, mdu_cnt_d;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;
  logic [HW-1:0] hold_run_q, hold_run_d;
  logic          timeout_q, timeout_d;

  logic ld_exe, ld_mem, ld_raw, mdu_raw, hold_raw, br_raw;

  // $0 never creates a dependency, and unused operand fields are ignored.
  function automatic logic src_match(input logic used, input logic [AW-1:0] src,
                                     input logic [AW-1:0] dst);
    return used && (src == dst) && (dst != '0);
  endfunction

  assign mdu_busy = (mdu_cnt_q != '0);

  always_comb begin
    ld_exe   = mem_read_IDEX && (src_match(src1_used_ID, src1_ID, dest_EXE) ||
                                 src_match(src2_used_ID, src2_ID, dest_EXE));
    ld_mem   = (LOAD_LAT >= 2) && mem_read_EXMEM &&
               (src_match(src1_used_ID, src1_ID, dest_MEM) ||
                src_match(src2_used_ID, src2_ID, dest_MEM));
    ld_raw   = ld_exe || ld_mem;
    mdu_raw  = hilo_use_ID && (mdu_busy || mdu_start_IDEX);
    hold_raw = ld_raw || mdu_raw;
    // Branch operands may be stale while stalled; redirect once the stall clears.
    br_raw   = ((branch && branchYes) || (jump != 2'b00)) && !hold_raw;

    ld_has_hazard     = ld_raw && !rst;
    mdu_hazard        = mdu_raw && !rst;
    hold              = hold_raw && !rst;
    branch_has_hazard = br_raw && !rst;
    bubble_IDEX       = hold;
    flush_IFID        = branch_has_hazard;
    hazard            = ld_has_hazard || mdu_hazard || branch_has_hazard;
  end

  always_comb begin
    mdu_cnt_d = mdu_cnt_q;
    if (mdu_start_IDEX) begin
      mdu_cnt_d = MW'(MDU_LAT);
    end else if (mdu_cnt_q != '0) begin
      mdu_cnt_d = mdu_cnt_q - MW'(1);
    end

    stall_cnt_d = stall_cnt_q;
    if (hold && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CW'(1);
    end

    hold_run_d = '0;
    if (hold) begin
      hold_run_d = (hold_run_q == HW'(MAX_HOLD)) ? hold_run_q : hold_run_q + HW'(1);
    end

    timeout_d = timeout_q || (hold && (hold_run_d == HW'(MAX_HOLD)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mdu_cnt_q   <= '0;
      stall_cnt_q <= '0;
      hold_run_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      mdu_cnt_q   <= mdu_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      hold_run_q  <= hold_run_d;
      timeout_q   <= timeout_d;
    end
  end

  assign stall_count  = stall_cnt_q;
  assign hold_timeout = timeout_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: a LOAD_LAT=1/CW=4 instance and a LOAD_LAT=2
// instance share stimulus; expectations are queued per cycle and checked on negedge.
module tb_hazard_ctrl_unit;

  localparam int S_LD = 0, S_MDU = 1, S_BR = 2, S_HZ = 3, S_HOLD = 4, S_BUB = 5,
                 S_FL = 6, S_BUSY = 7, S_CNT = 8, S_TO = 9;
  localparam int DA = 0, DB = 1;

  logic       clk, rst;
  logic [4:0] src1_ID, src2_ID, dest_EXE, dest_MEM;
  logic       src1_used_ID, src2_used_ID, hilo_use_ID, mem_read_IDEX, mem_read_EXMEM;
  logic       mdu_start_IDEX, branch, branchYes;
  logic [1:0] jump;

  logic        a_ld, a_mdu, a_br, a_hz, a_hold, a_bub, a_fl, a_busy, a_to;
  logic [3:0]  a_cnt;
  logic        b_ld, b_mdu, b_br, b_hz, b_hold, b_bub, b_fl, b_busy, b_to;
  logic [15:0] b_cnt;

  hazard_ctrl_unit #(.AW(5), .LOAD_LAT(1), .MDU_LAT(4), .MW(3), .CW(4), .MAX_HOLD(32)) u_a (
    .clk(clk), .rst(rst), .src1_ID(src1_ID), .src2_ID(src2_ID),
    .src1_used_ID(src1_used_ID), .src2_used_ID(src2_used_ID), .hilo_use_ID(hilo_use_ID),
    .dest_EXE(dest_EXE), .mem_read_IDEX(mem_read_IDEX), .dest_MEM(dest_MEM),
    .mem_read_EXMEM(mem_read_EXMEM), .mdu_start_IDEX(mdu_start_IDEX), .branch(branch),
    .branchYes(branchYes), .jump(jump), .ld_has_hazard(a_ld), .mdu_hazard(a_mdu),
    .branch_has_hazard(a_br), .hazard(a_hz), .hold(a_hold), .bubble_IDEX(a_bub),
    .flush_IFID(a_fl), .mdu_busy(a_busy), .stall_count(a_cnt), .hold_timeout(a_to)
  );

  hazard_ctrl_unit #(.AW(5), .LOAD_LAT(2), .MDU_LAT(4), .MW(3), .CW(16), .MAX_HOLD(32)) u_b (
    .clk(clk), .rst(rst), .src1_ID(src1_ID), .src2_ID(src2_ID),
    .src1_used_ID(src1_used_ID), .src2_used_ID(src2_used_ID), .hilo_use_ID(hilo_use_ID),
    .dest_EXE(dest_EXE), .mem_read_IDEX(mem_read_IDEX), .dest_MEM(dest_MEM),
    .mem_read_EXMEM(mem_read_EXMEM), .mdu_start_IDEX(mdu_start_IDEX), .branch(branch),
    .branchYes(branchYes), .jump(jump), .ld_has_hazard(b_ld), .mdu_hazard(b_mdu),
    .branch_has_hazard(b_br), .hazard(b_hz), .hold(b_hold), .bubble_IDEX(b_bub),
    .flush_IFID(b_fl), .mdu_busy(b_busy), .stall_count(b_cnt), .hold_timeout(b_to)
  );

  typedef struct {
    int    cyc;
    int    dut;
    int    sel;
    int    exp;
    string name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   mon_act;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int actual(input int dut, input int sel);
    if (dut == DA) begin
      case (sel)
        S_LD:    return int'(a_ld);
        S_MDU:   return int'(a_mdu);
        S_BR:    return int'(a_br);
        S_HZ:    return int'(a_hz);
        S_HOLD:  return int'(a_hold);
        S_BUB:   return int'(a_bub);
        S_FL:    return int'(a_fl);
        S_BUSY:  return int'(a_busy);
        S_CNT:   return int'(a_cnt);
        default: return int'(a_to);
      endcase
    end else begin
      case (sel)
        S_LD:    return int'(b_ld);
        S_MDU:   return int'(b_mdu);
        S_BR:    return int'(b_br);
        S_HZ:    return int'(b_hz);
        S_HOLD:  return int'(b_hold);
        S_BUB:   return int'(b_bub);
        S_FL:    return int'(b_fl);
        S_BUSY:  return int'(b_busy);
        S_CNT:   return int'(b_cnt);
        default: return int'(b_to);
      endcase
    end
  endfunction

  task automatic expect_val(input int dut, input int sel, input int exp, input string name);
    exp_t e;
    e.cyc  = cyc;
    e.dut  = dut;
    e.sel  = sel;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  // Monitor: compares every expectation due in the current cycle.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        mon_e   = sb.pop_front();
        mon_act = actual(mon_e.dut, mon_e.sel);
        n_checks++;
        if (mon_e.cyc != cyc || mon_act != mon_e.exp) begin
          n_errors++;
          $display("FAIL %s: actual=%0d required=%0d (cycle %0d)",
                   mon_e.name, mon_act, mon_e.exp, cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    src1_ID = '0; src2_ID = '0; dest_EXE = '0; dest_MEM = '0;
    src1_used_ID = 1'b0; src2_used_ID = 1'b0; hilo_use_ID = 1'b0;
    mem_read_IDEX = 1'b0; mem_read_EXMEM = 1'b0; mdu_start_IDEX = 1'b0;
    branch = 1'b0; branchYes = 1'b0; jump = 2'b00;
  endtask

  task automatic load_hazard();
    mem_read_IDEX = 1'b1; dest_EXE = 5'd8; src1_ID = 5'd8; src1_used_ID = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    clr();
    load_hazard();
    branch = 1'b1; branchYes = 1'b1;
    step();
    step();
    expect_val(DA, S_HOLD, 0, "rst_hold");
    expect_val(DA, S_HZ,   0, "rst_hazard");
    expect_val(DA, S_FL,   0, "rst_flush");
    expect_val(DA, S_CNT,  0, "rst_stall_count");
    expect_val(DA, S_BUSY, 0, "rst_mdu_busy");
    expect_val(DA, S_TO,   0, "rst_timeout");
    expect_val(DB, S_LD,   0, "rst_ld_b");

    // Load-use, EXE stage
    step(); rst = 1'b0; clr(); load_hazard();
    expect_val(DA, S_LD, 1, "lu_ld");
    expect_val(DA, S_HOLD, 1, "lu_hold");
    expect_val(DA, S_BUB, 1, "lu_bubble");
    expect_val(DA, S_HZ, 1, "lu_hazard");
    expect_val(DA, S_FL, 0, "lu_flush");
    step(); dest_EXE = 5'd0; src1_ID = 5'd0;
    expect_val(DA, S_HOLD, 0, "lu_r0_hold");
    expect_val(DA, S_CNT, 1, "lu_cnt1");
    step(); dest_EXE = 5'd8; src1_ID = 5'd8; src1_used_ID = 1'b0; src2_ID = 5'd8;
    expect_val(DA, S_HOLD, 0, "lu_unused_hold");
    step(); src2_used_ID = 1'b1;
    expect_val(DA, S_HOLD, 1, "lu_src2_hold");
    expect_val(DA, S_LD, 1, "lu_src2_ld");

    // Load-use, MEM stage: only the LOAD_LAT=2 instance reacts
    step(); clr(); mem_read_EXMEM = 1'b1; dest_MEM = 5'd9; src2_ID = 5'd9; src2_used_ID = 1'b1;
    expect_val(DA, S_LD, 0, "mem_ld_lat1");
    expect_val(DA, S_HOLD, 0, "mem_hold_lat1");
    expect_val(DB, S_LD, 1, "mem_ld_lat2");
    expect_val(DB, S_HOLD, 1, "mem_hold_lat2");
    expect_val(DA, S_CNT, 2, "mem_cnt2");
    step(); mem_read_EXMEM = 1'b0;
    expect_val(DB, S_LD, 0, "mem_noload_lat2");

    // Branch during stall, then redirect
    step(); clr(); load_hazard(); branch = 1'b1; branchYes = 1'b1;
    expect_val(DA, S_FL, 0, "br_stall_flush");
    expect_val(DA, S_BR, 0, "br_stall_br");
    expect_val(DA, S_HOLD, 1, "br_stall_hold");
    step(); mem_read_IDEX = 1'b0;
    expect_val(DA, S_FL, 1, "br_flush");
    expect_val(DA, S_BR, 1, "br_br");
    expect_val(DA, S_HZ, 1, "br_hazard");
    expect_val(DA, S_HOLD, 0, "br_hold");
    step(); branch = 1'b0; branchYes = 1'b0; jump = 2'b10;
    expect_val(DA, S_FL, 1, "jump_flush");
    expect_val(DA, S_BR, 1, "jump_br");
    step(); jump = 2'b00; branch = 1'b1;
    expect_val(DA, S_FL, 0, "br_nottaken_flush");
    expect_val(DA, S_HZ, 0, "br_nottaken_hazard");

    // MDU occupancy, with an overlapping load-use hazard at offset 2
    step(); clr(); mdu_start_IDEX = 1'b1; hilo_use_ID = 1'b1;
    expect_val(DA, S_MDU, 1, "mdu_c0");
    expect_val(DA, S_HOLD, 1, "mdu_c0_hold");
    expect_val(DA, S_BUSY, 0, "mdu_c0_busy");
    for (int i = 1; i <= 4; i++) begin
      step(); mdu_start_IDEX = 1'b0;
      if (i == 2) load_hazard();
      else mem_read_IDEX = 1'b0;
      expect_val(DA, S_MDU, 1, "mdu_busy_window");
      expect_val(DA, S_BUSY, 1, "mdu_busy_flag");
      expect_val(DA, S_HOLD, 1, "mdu_hold");
      if (i == 2) expect_val(DA, S_LD, 1, "mdu_ld_overlap");
    end
    step(); clr(); hilo_use_ID = 1'b1;
    expect_val(DA, S_MDU, 0, "mdu_c5");
    expect_val(DA, S_BUSY, 0, "mdu_c5_busy");
    expect_val(DA, S_CNT, 8, "mdu_stall_count");

    // 31-cycle stall: counter saturates, watchdog stays quiet
    for (int i = 0; i < 31; i++) begin
      step(); clr(); load_hazard();
    end
    step(); clr();
    expect_val(DA, S_CNT, 15, "cnt_saturate");
    expect_val(DA, S_TO, 0, "wd_31_quiet");
    // 32-cycle stall trips the watchdog
    for (int i = 0; i < 32; i++) begin
      step(); clr(); load_hazard();
      if (i == 31) expect_val(DA, S_TO, 0, "wd_pre_trip");
    end
    step(); clr();
    expect_val(DA, S_TO, 1, "wd_trip");
    expect_val(DA, S_CNT, 15, "cnt_still_sat");
    step();
    expect_val(DA, S_TO, 1, "wd_sticky");

    // Reset forces outputs low and clears state
    step(); rst = 1'b1; load_hazard(); branch = 1'b1; branchYes = 1'b1;
    mdu_start_IDEX = 1'b1; hilo_use_ID = 1'b1;
    expect_val(DA, S_LD, 0, "rstf_ld");
    expect_val(DA, S_MDU, 0, "rstf_mdu");
    expect_val(DA, S_BR, 0, "rstf_br");
    expect_val(DA, S_HZ, 0, "rstf_hazard");
    expect_val(DA, S_HOLD, 0, "rstf_hold");
    expect_val(DA, S_BUB, 0, "rstf_bubble");
    expect_val(DA, S_FL, 0, "rstf_flush");
    expect_val(DB, S_LD, 0, "rstf_ld_b");
    step(); rst = 1'b0; clr();
    expect_val(DA, S_TO, 0, "rstf_timeout");
    expect_val(DA, S_CNT, 0, "rstf_cnt");
    expect_val(DA, S_BUSY, 0, "rstf_busy");

    // Reset mid-MDU aborts the busy window
    step(); mdu_start_IDEX = 1'b1; hilo_use_ID = 1'b1;
    expect_val(DA, S_MDU, 1, "mid_c0_mdu");
    step(); mdu_start_IDEX = 1'b0;
    expect_val(DA, S_BUSY, 1, "mid_c1_busy");
    expect_val(DA, S_MDU, 1, "mid_c1_mdu");
    step(); rst = 1'b1;
    expect_val(DA, S_MDU, 0, "mid_c2_mdu");
    expect_val(DA, S_HOLD, 0, "mid_c2_hold");
    step(); rst = 1'b0;
    expect_val(DA, S_BUSY, 0, "mid_c3_busy");
    expect_val(DA, S_MDU, 0, "mid_c3_mdu");
    expect_val(DA, S_CNT, 0, "mid_c3_cnt");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      $display("FAIL scoreboard_drain: actual=%0d pending required=0", sb.size());
      n_errors = n_errors + sb.size();
      n_checks = n_checks + sb.size();
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
